// File: rtl/ixc_assign_rev_skid.sv
// Registered L->R assign cell: a 2-entry skid buffer carrying WIDTH-bit words
// over valid/ready, so that l_ready comes straight from the state register.
module ixc_assign_rev_skid #(
    parameter int WIDTH = 10,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             l_valid,
    input  logic [WIDTH-1:0] l_data,
    output logic             l_ready,
    output logic             r_valid,
    output logic [WIDTH-1:0] r_data,
    input  logic             r_ready,
    output logic [1:0]       occ,
    output logic [CNT_W-1:0] xfer_cnt
);

    // Handshake: a word moves on an edge where valid and ready are both high
    // (push on L, pop on R). A source holding valid must keep its data
    // stable until ready is seen. Ready never waits on valid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] head, head_nx;
    logic [WIDTH-1:0] skid, skid_nx;
    logic             push, pop;

    // Every output decodes registered state only; no r_ready -> l_ready path.
    assign l_ready = (state != FULL);
    assign r_valid = (state != EMPTY);
    assign r_data  = head;
    assign occ     = state;

    assign push = l_valid & l_ready;
    assign pop  = r_valid & r_ready;

    always_comb begin
        state_nx = state;
        head_nx  = head;
        skid_nx  = skid;
        case (state)
            EMPTY: begin
                if (push) begin
                    state_nx = HALF;
                    head_nx  = l_data;
                end
            end
            HALF: begin
                if (push && !pop) begin
                    state_nx = FULL;
                    skid_nx  = l_data;
                end else if (push && pop) begin
                    head_nx = l_data;
                end else if (pop) begin
                    state_nx = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_nx = HALF;
                    head_nx  = skid;
                end
            end
            default: state_nx = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            head     <= '0;
            skid     <= '0;
            xfer_cnt <= '0;
        end else begin
            state <= state_nx;
            head  <= head_nx;
            skid  <= skid_nx;
            if (push) begin
                xfer_cnt <= xfer_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_ixc_assign_rev_skid.sv
// Bench for ixc_assign_rev_skid: directed scenarios plus random traffic, all
// checked each cycle against a queue model of a depth-2 FIFO.
module tb_ixc_assign_rev_skid;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         l_valid;
    logic [W-1:0] l_data;
    logic         r_ready;
    logic         l_ready, r_valid;
    logic [W-1:0] r_data;
    logic [1:0]   occ;
    logic [15:0]  xfer_cnt;
    logic         l_ready4, r_valid4;
    logic [W-1:0] r_data4;
    logic [1:0]   occ4;
    logic [3:0]   xfer_cnt4;

    int compared   = 0;
    int mismatched = 0;
    bit started    = 1'b0;

    // Model state: FIFO contents, push count, last word shown on r_data.
    logic [W-1:0] exp_q[$];
    int           m_cnt  = 0;
    logic [W-1:0] m_last = '0;

    always #5 clk = ~clk;

    ixc_assign_rev_skid #(.WIDTH(W), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .l_valid(l_valid), .l_data(l_data),
        .l_ready(l_ready), .r_valid(r_valid), .r_data(r_data),
        .r_ready(r_ready), .occ(occ), .xfer_cnt(xfer_cnt)
    );

    ixc_assign_rev_skid #(.WIDTH(W), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .l_valid(l_valid), .l_data(l_data),
        .l_ready(l_ready4), .r_valid(r_valid4), .r_data(r_data4),
        .r_ready(r_ready), .occ(occ4), .xfer_cnt(xfer_cnt4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Model update: inputs are stable at the rising edge (driven on falling).
    always @(posedge clk) begin
        bit p_push, p_pop;
        if (rst) begin
            exp_q.delete();
            m_cnt  = 0;
            m_last = '0;
        end else begin
            p_push = l_valid && (exp_q.size() < 2);
            p_pop  = (exp_q.size() > 0) && r_ready;
            if (p_pop) void'(exp_q.pop_front());
            if (p_push) begin
                exp_q.push_back(l_data);
                m_cnt++;
            end
            if (exp_q.size() > 0) m_last = exp_q[0];
        end
        started = 1'b1;
    end

    // Compare process: both instances against the model on every falling edge.
    always @(negedge clk) begin
        if (started) begin
            chk("l_ready",   32'(l_ready),   32'(exp_q.size() < 2));
            chk("r_valid",   32'(r_valid),   32'(exp_q.size() > 0));
            chk("r_data",    32'(r_data),    32'(m_last));
            chk("occ",       32'(occ),       32'(exp_q.size()));
            chk("xfer_cnt",  32'(xfer_cnt),  32'(m_cnt % 65536));
            chk("occ4",      32'(occ4),      32'(exp_q.size()));
            chk("r_data4",   32'(r_data4),   32'(m_last));
            chk("xfer_cnt4", 32'(xfer_cnt4), 32'(m_cnt % 16));
        end
    end

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; l_valid = 1'b1; l_data = 10'h3FF; r_ready = 1'b0;
        @(negedge clk);
        // Reset with an offer pending must leave everything cleared.
        do_reset(2);
        chk("rst_l_ready", 32'(l_ready), 32'd1);
        chk("rst_r_valid", 32'(r_valid), 32'd0);
        chk("rst_r_data", 32'(r_data), 32'd0);
        chk("rst_occ", 32'(occ), 32'd0);
        chk("rst_cnt", 32'(xfer_cnt), 32'd0);

        // Single word, then drain.
        l_valid = 1'b1; l_data = 10'h155; r_ready = 1'b0;
        step();
        chk("single_data", 32'(r_data), 32'h155);
        chk("single_occ", 32'(occ), 32'd1);
        chk("single_valid", 32'(r_valid), 32'd1);
        l_valid = 1'b0; r_ready = 1'b1;
        step();
        chk("single_drain_occ", 32'(occ), 32'd0);
        chk("single_drain_valid", 32'(r_valid), 32'd0);
        chk("single_cnt", 32'(xfer_cnt), 32'd1);

        // Back-pressure fill, third word held off, then release.
        r_ready = 1'b0; l_valid = 1'b1; l_data = 10'h001;
        step();
        l_data = 10'h002;
        step();
        chk("fill_occ", 32'(occ), 32'd2);
        chk("fill_l_ready", 32'(l_ready), 32'd0);
        l_data = 10'h003;
        step();
        chk("held_occ", 32'(occ), 32'd2);
        chk("held_head", 32'(r_data), 32'h001);
        chk("held_cnt", 32'(xfer_cnt), 32'd3);
        r_ready = 1'b1;
        step();
        chk("drain_1", 32'(r_data), 32'h002);
        step();
        chk("drain_2", 32'(r_data), 32'h003);
        chk("drain_cnt", 32'(xfer_cnt), 32'd4);
        l_valid = 1'b0;
        step();
        chk("drain_empty", 32'(occ), 32'd0);

        // Streaming 64 words with r_ready held high.
        do_reset(2);
        r_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            l_valid = 1'b1; l_data = W'(i);
            step();
            chk("stream_data", 32'(r_data), 32'(i));
            chk("stream_occ", 32'(occ), 32'd1);
        end
        l_valid = 1'b0;
        step();
        chk("stream_cnt", 32'(xfer_cnt), 32'd64);
        chk("stream_cnt4", 32'(xfer_cnt4), 32'd0);

        // Narrow counter wrap: 17 pushes.
        do_reset(1);
        for (int i = 0; i < 17; i++) begin
            l_valid = 1'b1; l_data = W'($urandom_range(0, 1023));
            step();
        end
        l_valid = 1'b0;
        step();
        chk("wrap_cnt4", 32'(xfer_cnt4), 32'd1);
        chk("wrap_cnt", 32'(xfer_cnt), 32'd17);

        // Simultaneous push and pop while HALF.
        r_ready = 1'b0; l_valid = 1'b1; l_data = 10'h0AA;
        step();
        r_ready = 1'b1; l_data = 10'h2BB;
        step();
        chk("pushpop_data", 32'(r_data), 32'h2BB);
        chk("pushpop_occ", 32'(occ), 32'd1);
        l_valid = 1'b0;
        step();

        // Reset while FULL discards both words.
        r_ready = 1'b0; l_valid = 1'b1; l_data = 10'h111;
        step();
        l_data = 10'h222;
        step();
        chk("midrst_full", 32'(occ), 32'd2);
        l_valid = 1'b0;
        do_reset(1);
        chk("midrst_occ", 32'(occ), 32'd0);
        chk("midrst_valid", 32'(r_valid), 32'd0);
        r_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("midrst_gone", 32'(r_valid), 32'd0);

        // Random traffic, junk data while idle, occasional reset.
        for (int i = 0; i < 2000; i++) begin
            rst     = ($urandom_range(0, 99) == 0);
            l_valid = ($urandom_range(0, 3) != 0);
            l_data  = W'($urandom_range(0, 1023));
            r_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
